rob_multi_wb: RTL

//  Parametrised reorder buffer (ROB) between dispatcher and commit stage. Circular queue of DEPTH entries.

---
 rtl/rob_multi_wb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/rob_multi_wb.sv
// rtl/rob_multi_wb.sv - reorder buffer with multi-channel writeback, in-order commit and branch/JALR redirect
//
// Ports:
//   clk, rst (async, active-low), rdy (global enable, low holds all state)
//   issue_*        : dispatcher allocation; issue_rob_id is the tag given (current tail)
//   full           : no allocation allowed this cycle (count >= DEPTH-FULL_MARGIN)
//   wb_*           : NUM_WB writeback channels, channel k in slice k of each packed bus
//   store_req/_id  : store waiting at head for the LSB; store_done marks it performed
//   commit_*       : registered one-cycle pulse per retired entry
//   pred_upt_*     : registered pulse with the actual outcome of a retired branch
//   flush/flush_pc : registered pulse on mispredict or JALR, with the redirect PC
module rob_multi_wb #(
    parameter int DEPTH       = 16,
    parameter int IDX_W       = 4,
    parameter int NUM_WB      = 2,
    parameter int XLEN        = 32,
    parameter int PRED_W      = 5,
    parameter int FULL_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     issue_en,
    input  logic [1:0]               issue_kind,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_pred_tk,
    input  logic [PRED_W-1:0]        issue_pred_idx,
    output logic [IDX_W-1:0]         issue_rob_id,
    output logic                     full,
    input  logic [NUM_WB-1:0]        wb_en,
    input  logic [NUM_WB*IDX_W-1:0]  wb_rob_id,
    input  logic [NUM_WB*XLEN-1:0]   wb_val,
    input  logic [NUM_WB*XLEN-1:0]   wb_pc,
    input  logic [NUM_WB-1:0]        wb_taken,
    output logic                     store_req,
    output logic [IDX_W-1:0]         store_rob_id,
    input  logic                     store_done,
    output logic                     commit_en,
    output logic [IDX_W-1:0]         commit_rob_id,
    output logic [4:0]               commit_rd,
    output logic [XLEN-1:0]          commit_val,
    output logic                     pred_upt_en,
    output logic [PRED_W-1:0]        pred_upt_idx,
    output logic                     pred_upt_tk,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_pc
);

    localparam logic [1:0]     K_BR    = 2'd1;
    localparam logic [1:0]     K_JALR  = 2'd2;
    localparam logic [1:0]     K_ST    = 2'd3;
    localparam logic [IDX_W:0] FULL_TH = (IDX_W+1)'(DEPTH - FULL_MARGIN);

    // Per-entry control state (reset) and payload (no reset: only read once busy && ready)
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_ready;
    logic [1:0]        r_kind     [DEPTH];
    logic [4:0]        r_rd       [DEPTH];
    logic [PRED_W-1:0] r_pred_idx [DEPTH];
    logic [XLEN-1:0]   r_val      [DEPTH];
    logic [XLEN-1:0]   r_pc       [DEPTH];
    logic [DEPTH-1:0]  r_pred_tk;
    logic [DEPTH-1:0]  r_taken;

    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [IDX_W:0]    r_count;

    logic              r_commit_en;
    logic [IDX_W-1:0]  r_commit_rob_id;
    logic [4:0]        r_commit_rd;
    logic [XLEN-1:0]   r_commit_val;
    logic              r_pred_upt_en;
    logic [PRED_W-1:0] r_pred_upt_idx;
    logic              r_pred_upt_tk;
    logic              r_flush;
    logic [XLEN-1:0]   r_flush_pc;

    logic              w_live;
    logic              w_full;
    logic              w_issue_acc;
    logic              w_commit;
    logic              w_store_ack;
    logic              w_mispred;
    logic [1:0]        w_head_kind;
    logic [NUM_WB-1:0] w_wb_ok;
    logic [IDX_W-1:0]  w_wb_tag [NUM_WB];

    // Nothing but the flush itself happens in the cycle a flush is presented
    assign w_live      = rdy && !r_flush;
    assign w_full      = (r_count >= FULL_TH);
    assign w_head_kind = r_kind[r_head];
    assign w_issue_acc = w_live && issue_en && !w_full;
    assign w_commit    = w_live && r_busy[r_head] && r_ready[r_head];
    assign w_store_ack = w_live && store_done && r_busy[r_head] && (w_head_kind == K_ST) && !r_ready[r_head];
    assign w_mispred   = (w_head_kind == K_JALR) ||
                         ((w_head_kind == K_BR) && (r_taken[r_head] != r_pred_tk[r_head]));

    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            w_wb_tag[k] = wb_rob_id[k*IDX_W +: IDX_W];
            w_wb_ok[k]  = w_live && wb_en[k] && r_busy[w_wb_tag[k]] && (r_kind[w_wb_tag[k]] != K_ST);
        end
    end

    // Payload: later channels are written last, so the highest channel wins a shared tag
    always_ff @(posedge clk) begin
        if (w_issue_acc) begin
            r_kind[r_tail]     <= issue_kind;
            r_rd[r_tail]       <= issue_rd;
            r_pred_tk[r_tail]  <= issue_pred_tk;
            r_pred_idx[r_tail] <= issue_pred_idx;
        end
        for (int k = 0; k < NUM_WB; k++) begin
            if (w_wb_ok[k]) begin
                r_val[w_wb_tag[k]]   <= wb_val[k*XLEN +: XLEN];
                r_pc[w_wb_tag[k]]    <= wb_pc[k*XLEN +: XLEN];
                r_taken[w_wb_tag[k]] <= wb_taken[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy          <= '0;
            r_ready         <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_commit_en     <= 1'b0;
            r_commit_rob_id <= '0;
            r_commit_rd     <= '0;
            r_commit_val    <= '0;
            r_pred_upt_en   <= 1'b0;
            r_pred_upt_idx  <= '0;
            r_pred_upt_tk   <= 1'b0;
            r_flush         <= 1'b0;
            r_flush_pc      <= '0;
        end else if (r_flush) begin
            // Completed even when rdy is low: the redirect has already left, so the
            // wrong-path entries must not survive past this edge.
            r_busy        <= '0;
            r_ready       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_commit_en   <= 1'b0;
            r_pred_upt_en <= 1'b0;
            r_flush       <= 1'b0;
        end else begin
            r_commit_en   <= w_commit;
            r_pred_upt_en <= w_commit && (w_head_kind == K_BR);
            r_flush       <= w_commit && w_mispred;
            for (int k = 0; k < NUM_WB; k++) begin
                if (w_wb_ok[k]) begin
                    r_ready[w_wb_tag[k]] <= 1'b1;
                end
            end
            if (w_store_ack) begin
                r_ready[r_head] <= 1'b1;
            end
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
                r_commit_rob_id <= r_head;
                r_commit_rd     <= (w_head_kind == K_BR) ? 5'd0 : r_rd[r_head];
                r_commit_val    <= r_val[r_head];
                if (w_head_kind == K_BR) begin
                    r_pred_upt_idx <= r_pred_idx[r_head];
                    r_pred_upt_tk  <= r_taken[r_head];
                end
                if (w_mispred) begin
                    r_flush_pc <= r_pc[r_head];
                end
            end
            if (w_issue_acc) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + IDX_W'(1);
            end
            r_count <= r_count + (IDX_W+1)'(w_issue_acc) - (IDX_W+1)'(w_commit);
        end
    end

    assign issue_rob_id  = r_tail;
    assign full          = w_full;
    assign store_req     = r_busy[r_head] && (w_head_kind == K_ST) && !r_ready[r_head] && !r_flush;
    assign store_rob_id  = r_head;
    assign commit_en     = r_commit_en;
    assign commit_rob_id = r_commit_rob_id;
    assign commit_rd     = r_commit_rd;
    assign commit_val    = r_commit_val;
    assign pred_upt_en   = r_pred_upt_en;
    assign pred_upt_idx  = r_pred_upt_idx;
    assign pred_upt_tk   = r_pred_upt_tk;
    assign flush         = r_flush;
    assign flush_pc      = r_flush_pc;

endmodule
